// File: rtl/note_pkg.sv
// Shared note codes, tone frequency table and half-period helper for note_player.
package note_pkg;

  typedef logic [3:0] note_t;

  localparam note_t       NOTE_REST = 4'd0;
  localparam note_t       NOTE_C4   = 4'd1;
  localparam note_t       NOTE_C5   = 4'd13;
  localparam int unsigned HP_W      = 20;

  function automatic logic is_tone(input note_t code);
    return (code >= NOTE_C4) && (code <= NOTE_C5);
  endfunction

  // Tone frequencies in centi-hertz, C4 up to C5 in semitone steps; rests map to 0.
  function automatic int unsigned freq_chz(input note_t code);
    case (code)
      4'd1:    return 26163;
      4'd2:    return 27718;
      4'd3:    return 29366;
      4'd4:    return 31113;
      4'd5:    return 32963;
      4'd6:    return 34923;
      4'd7:    return 36999;
      4'd8:    return 39200;
      4'd9:    return 41530;
      4'd10:   return 44000;
      4'd11:   return 46616;
      4'd12:   return 49388;
      4'd13:   return 52325;
      default: return 0;
    endcase
  endfunction

  // Half-period in clock cycles, rounded to nearest: round(clk_hz*100 / (2*f_cHz)).
  function automatic logic [HP_W-1:0] half_period(input longint unsigned clk_hz,
                                                  input note_t           code);
    longint unsigned f;
    longint unsigned hp;
    f = 64'(freq_chz(code));
    if (f == 64'd0) return '0;
    hp = (clk_hz * 64'd100 + f) / (64'd2 * f);
    return hp[HP_W-1:0];
  endfunction

endpackage

// File: rtl/note_player_tone_gen.sv
// tone_gen: 20-bit half-period down-counter driving a square wave, with phase restart.
module tone_gen
  import note_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [HP_W-1:0] half_period,
  input  logic            enable,
  input  logic            restart,
  output logic            wave
);

  logic [HP_W-1:0] count;

  // Restart always begins a low half-cycle, so every new tone has a known phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      wave  <= 1'b0;
    end else if (!enable) begin
      count <= '0;
      wave  <= 1'b0;
    end else if (restart) begin
      count <= half_period - 20'd1;
      wave  <= 1'b0;
    end else if (count == '0) begin
      count <= half_period - 20'd1;
      wave  <= ~wave;
    end else begin
      count <= count - 20'd1;
    end
  end

endmodule

// File: rtl/note_player.sv
// note_player: 16-slot note memory with registered playback and square-wave tone output.
// Define NOTE_GAP_EN to insert GAP_CYCLES of silence at each note start.
module note_player
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned GAP_CYCLES = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_note,
  input  logic       ld_play,
  input  logic       next_note_en,
  input  logic [3:0] note_in,
  input  logic [3:0] wr_addr,
  input  logic [3:0] rd_addr,
  output logic       audio_out,
  output logic [3:0] cur_note,
  output logic       playing
);

  note_t           mem    [16];
  logic [HP_W-1:0] hp_rom [16];
  note_t           next_note;
  logic            play_active;
  logic            tone_enable;
  logic            tone_restart;

  if (GAP_CYCLES > 32'h003F_FFFF) begin : g_gap_range
    $error("note_player: GAP_CYCLES does not fit the 22-bit gap counter");
  end

  // Half-periods are elaboration-time constants, so the lookup is a plain ROM.
  for (genvar i = 0; i < 16; i++) begin : g_hp_rom
    localparam logic [HP_W-1:0] HP = half_period(64'(CLK_HZ), note_t'(i));
    assign hp_rom[i] = HP;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= NOTE_REST;
    end else if (ld_note) begin
      mem[wr_addr] <= note_in;
    end
  end

  // Recording takes priority: while ld_note is high, playback behaves as if stopped.
  assign play_active = ld_play && !ld_note;
  assign next_note   = play_active ? mem[rd_addr] : NOTE_REST;
  assign tone_enable = is_tone(next_note);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_note <= NOTE_REST;
      playing  <= 1'b0;
    end else begin
      cur_note <= next_note;
      playing  <= play_active && is_tone(cur_note);
    end
  end

`ifdef NOTE_GAP_EN
  localparam logic [21:0] GAP_LOAD = 22'(GAP_CYCLES);

  logic [21:0] gap_count;
  logic        ld_play_q;
  logic        gap_load;

  // A fresh playback start or an explicit advance reopens the silence window.
  assign gap_load = ld_play && (!ld_play_q || next_note_en);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_count <= '0;
      ld_play_q <= 1'b0;
    end else begin
      ld_play_q <= ld_play;
      if (gap_load) begin
        gap_count <= GAP_LOAD;
      end else if (gap_count != '0) begin
        gap_count <= gap_count - 22'd1;
      end
    end
  end

  assign tone_restart = (next_note != cur_note) || gap_load || (gap_count != '0);
`else
  logic unused_next_note_en;
  assign unused_next_note_en = next_note_en;

  assign tone_restart = (next_note != cur_note);
`endif

  tone_gen u_tone_gen (
    .clk         (clk),
    .reset       (reset),
    .half_period (hp_rom[next_note]),
    .enable      (tone_enable),
    .restart     (tone_restart),
    .wave        (audio_out)
  );

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: directed scenarios plus randomized traffic checked every cycle
// against a time-based model. Add +define+NOTE_GAP_EN to also cover the note gap.
module tb_note_player;
  import note_pkg::*;

  localparam int unsigned CLK_TB = 100000;
  localparam int unsigned GAP_TB = 100;
  localparam longint      GAP_L  = 100;
`ifdef NOTE_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       ld_note;
  logic       ld_play;
  logic       next_note_en;
  logic [3:0] note_in;
  logic [3:0] wr_addr;
  logic [3:0] rd_addr;
  logic       audio_out;
  logic [3:0] cur_note;
  logic       playing;

  int n_checks = 0;
  int n_bad    = 0;

  logic [3:0] m_mem [16];
  logic [3:0] m_cur;
  logic       m_playing;
  logic       m_prev_play;
  longint     n_edge;
  longint     change_edge;
  longint     gap_edge;

  note_player #(.CLK_HZ(CLK_TB), .GAP_CYCLES(GAP_TB)) dut (
    .clk          (clk),
    .reset        (reset),
    .ld_note      (ld_note),
    .ld_play      (ld_play),
    .next_note_en (next_note_en),
    .note_in      (note_in),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .audio_out    (audio_out),
    .cur_note     (cur_note),
    .playing      (playing)
  );

  always #5 clk = ~clk;

  // Musical pitches in Hz; half-period = clock / (2 * pitch), rounded.
  function automatic longint hp_ref(input int code);
    real f;
    case (code)
      1:  f = 261.63;
      2:  f = 277.18;
      3:  f = 293.66;
      4:  f = 311.13;
      5:  f = 329.63;
      6:  f = 349.23;
      7:  f = 369.99;
      8:  f = 392.00;
      9:  f = 415.30;
      10: f = 440.00;
      11: f = 466.16;
      12: f = 493.88;
      13: f = 523.25;
      default: f = 0.0;
    endcase
    if (f == 0.0) return 0;
    return longint'($rtoi(real'(CLK_TB) / (2.0 * f) + 0.5));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 4'd0;
    m_cur       = 4'd0;
    m_playing   = 1'b0;
    m_prev_play = 1'b0;
    change_edge = 0;
    gap_edge    = -1000000;
  endfunction

  function automatic void model_edge();
    logic [3:0] nxt;
    logic       eff;
    n_edge++;
    eff = ld_play && !ld_note;
    nxt = eff ? m_mem[rd_addr] : 4'd0;
    if (ld_note) m_mem[wr_addr] = note_in;
    if (ld_play && (!m_prev_play || next_note_en)) gap_edge = n_edge;
    m_prev_play = ld_play;
    m_playing   = eff && (m_cur >= 4'd1) && (m_cur <= 4'd13);
    if (nxt != m_cur) change_edge = n_edge;
    m_cur = nxt;
  endfunction

  // The wave is low from its start edge, flipping once per elapsed half-period.
  function automatic logic exp_audio();
    longint start;
    if (m_cur < 4'd1 || m_cur > 4'd13) return 1'b0;
    start = change_edge;
    if (GAP_ON && (gap_edge + GAP_L > start)) start = gap_edge + GAP_L;
    if (n_edge < start) return 1'b0;
    return (((n_edge - start) / hp_ref(int'(m_cur))) % 2) == 1;
  endfunction

  task automatic check_output(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, n_edge);
    end
  endtask

  task automatic apply_stimulus(input logic ln, input logic lp, input logic nn,
                                input logic [3:0] ni, input logic [3:0] wa,
                                input logic [3:0] ra);
    ld_note      = ln;
    ld_play      = lp;
    next_note_en = nn;
    note_in      = ni;
    wr_addr      = wa;
    rd_addr      = ra;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_output("audio_out", audio_out, exp_audio());
    check_output("cur_note", cur_note, m_cur);
    check_output("playing", playing, m_playing);
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) tick();
  endtask

  task automatic wait_level(input string tag, input logic level, input int bound);
    bit seen;
    seen = (audio_out == level);
    for (int k = 0; k < bound && !seen; k++) begin
      tick();
      seen = (audio_out == level);
    end
    if (!seen) check_output({tag, "_timeout"}, 0, 1);
  endtask

  task automatic measure_half(input string tag, input int code);
    longint t0;
    logic   lvl;
    int     bound;
    bit     seen;
    bound = int'(hp_ref(code)) * 2 + int'(GAP_TB) + 20;
    lvl  = audio_out;
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      tick();
      seen = (audio_out != lvl);
    end
    if (!seen) begin
      check_output({tag, "_timeout"}, 0, 1);
      return;
    end
    t0   = n_edge;
    lvl  = audio_out;
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      tick();
      seen = (audio_out != lvl);
    end
    if (!seen) begin
      check_output({tag, "_timeout"}, 0, 1);
      return;
    end
    check_output(tag, n_edge - t0, hp_ref(code));
  endtask

  initial begin
    logic       r_ln;
    logic       r_lp;
    logic [3:0] r_ni;
    logic [3:0] r_wa;
    logic [3:0] r_ra;
    int         r_len;
    int         wait_bound;

    n_edge = 0;
    reset  = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    model_reset();
    #2 reset = 1'b0;
    #2;
    check_output("rst_audio", audio_out, 0);
    check_output("rst_cur_note", cur_note, 0);
    check_output("rst_playing", playing, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    check_output("hp50_c10", half_period(64'd50000000, 4'd10), 56818);
    check_output("hp50_c1", half_period(64'd50000000, 4'd1), 95555);
    check_output("hp50_c13", half_period(64'd50000000, 4'd13), 47778);
    check_output("hp50_rest", half_period(64'd50000000, 4'd14), 0);

    wait_bound = 2 * 191 + int'(GAP_TB) + 20;

    // Record A4 at slot 0 and play it.
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'd10, 4'd0, 4'd0);
    tick();
    apply_stimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
    tick();
    check_output("play_cur_note", cur_note, 10);
    measure_half("hp_c10", 10);
    check_output("play_playing", playing, 1);

    // Slots 0..2 = C4, C5, rest; step through them with phase resets.
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 4'd0);
    tick();
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'd13, 4'd1, 4'd0);
    tick();
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 4'd0);
    tick();
    apply_stimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
    tick();
    measure_half("hp_c1", 1);
    wait_level("c1_high", 1'b1, wait_bound);
    apply_stimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd1);
    tick();
    check_output("phase_reset_c13", audio_out, 0);
    measure_half("hp_c13", 13);
    wait_level("c13_high", 1'b1, wait_bound);
    apply_stimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd2);
    tick();
    check_output("rest_audio", audio_out, 0);
    tick();
    check_output("rest_playing", playing, 0);
    run(50);

    // Holding ld_note keeps only the last value written.
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'd3, 4'd4, 4'd0);
    tick();
    tick();
    tick();
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'd7, 4'd4, 4'd0);
    tick();
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'd5, 4'd4, 4'd0);
    tick();
    apply_stimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd4);
    tick();
    check_output("rec_last_slot4", cur_note, 5);
    run(300);

    // Record and play together: write lands, playback is muted.
    apply_stimulus(1'b1, 1'b1, 1'b0, 4'd9, 4'd6, 4'd4);
    run(10);
    check_output("both_cur_note", cur_note, 0);
    check_output("both_audio", audio_out, 0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd6);
    tick();
    check_output("both_write", cur_note, 9);

    // Asynchronous reset in the middle of a high half-cycle.
    apply_stimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd1);
    tick();
    wait_level("pre_reset_high", 1'b1, wait_bound);
    #3 reset = 1'b0;
    #1;
    check_output("rst_mid_audio", audio_out, 0);
    check_output("rst_mid_cur_note", cur_note, 0);
    check_output("rst_mid_playing", playing, 0);
    model_reset();
    apply_stimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    for (int a = 0; a < 16; a++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'(a));
      tick();
      check_output("slot_cleared", cur_note, 0);
    end

    // Randomized record/playback traffic.
    for (int s = 0; s < 60; s++) begin
      r_ln  = ($urandom_range(0, 3) == 0);
      r_lp  = ($urandom_range(0, 3) != 0);
      r_ni  = 4'($urandom);
      r_wa  = 4'($urandom);
      r_ra  = 4'($urandom);
      r_len = int'($urandom_range(1, 300));
      for (int c = 0; c < r_len; c++) begin
        apply_stimulus(r_ln, r_lp, ($urandom_range(0, 15) == 0), r_ni, r_wa, r_ra);
        tick();
      end
    end

`ifdef NOTE_GAP_EN
    // An advance tick during playback silences the note, then restarts it low.
    begin
      int  k;
      bit  seen;
      apply_stimulus(1'b1, 1'b0, 1'b0, 4'd10, 4'd3, 4'd0);
      tick();
      apply_stimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd3);
      run(int'(GAP_TB) + 300);
      apply_stimulus(1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd3);
      tick();
      check_output("gap_start_audio", audio_out, 0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd3);
      k    = 0;
      seen = 1'b0;
      while (!seen && k < int'(GAP_TB) + 400) begin
        tick();
        k++;
        seen = (audio_out == 1'b1);
      end
      if (!seen) check_output("gap_first_rise_timeout", 0, 1);
      else check_output("gap_first_rise", k, GAP_L + hp_ref(10));
    end
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/note_player.md
NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning the clk frequency in Hz used for the tone table.
REQ-002 SHALL have parameter GAP_CYCLES, default 2500000, meaning the silence length in cycles at each note start (used only with NOTE_GAP_EN).
REQ-003 SHALL have port clk  input  1  system clock; all flops rise-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ld_note  input  1  record strobe from the sequencer control.
REQ-006 SHALL have port ld_play  input  1  playback-active from the sequencer control.
REQ-007 SHALL have port next_note_en  input  1  one-cycle note-advance tick.
REQ-008 SHALL have port note_in  input  4  note code to record: 0=rest, 1..13=C4..C5 semitones, 14..15=rest.
REQ-009 SHALL have port wr_addr  input  4  record slot (notes_recorded).
REQ-010 SHALL have port rd_addr  input  4  playback slot (note_counter).
REQ-011 SHALL have port audio_out  output  1  square-wave audio.
REQ-012 SHALL have port cur_note  output  4  registered code of the note being played.
REQ-013 SHALL have port playing  output  1  high while a non-rest note sounds.

Function
REQ-014 SHALL hold a 16x4 note memory; when ld_note=1, mem[wr_addr] <= note_in every cycle, so the last value before ld_note falls is kept.
REQ-015 SHALL, when ld_play=1, register cur_note <= mem[rd_addr] with 1-cycle latency; when ld_play=0, cur_note <= 0.
REQ-016 SHALL treat ld_note=1 with ld_play=1 as ld_note-only: the write happens, cur_note <= 0, and audio is muted.
REQ-017 SHALL map codes 1..13 to half-period HP = round(CLK_HZ*100/(2*f_cHz)) with f_cHz in {26163,27718,29366,31113,32963,34923,36999,39200,41530,44000,46616,49388,52325}.
REQ-018 SHALL use a 20-bit down-counter: at 0, toggle audio_out and reload HP-1; otherwise decrement.
REQ-019 SHALL, when cur_note changes, reload the counter with HP-1 of the new note and force audio_out=0 in the same cycle (phase reset).
REQ-020 SHALL, for a rest code or ld_play=0, hold audio_out=0 and the counter at 0.
REQ-021 SHALL drive playing <= (ld_play && cur_note in 1..13), registered.
REQ-022 SHALL let a mid-note rd_addr wrap (15->0 or n->0) take effect via REQ-019; no other state is disturbed.

Reset
REQ-023 SHALL, on reset=0 (asynchronous), immediately clear audio_out, cur_note, playing, the tone counter, the gap counter, and all 16 memory entries to 0.
REQ-024 SHALL, on reset mid-note, silence audio in the same cycle and resume only after reset release plus the REQ-015 latency.

Configuration
REQ-025 SHALL support macro NOTE_GAP_EN; when defined, a 22-bit gap counter loads GAP_CYCLES on the ld_play rising edge or on next_note_en=1 while ld_play=1, counts down to 0, and forces audio_out=0 with the tone counter held in reload while nonzero.
REQ-026 SHALL, without NOTE_GAP_EN, contain no gap logic, so audio starts on the cycle after cur_note updates.

Structure
REQ-027 SHALL place the note-code localparams, the f_cHz table and the half-period function in shared package note_pkg.
REQ-028 SHALL implement the down-counter/toggle in one sub-module tone_gen (ports: clk, reset, half_period, enable, restart, wave).

Verification
REQ-029 SHALL verify at CLK_HZ=50000000: record code 10 at slot 0, ld_play=1 with rd_addr=0 -> cur_note=10 after 1 cycle, audio_out toggles every 56818 cycles, playing=1.
REQ-030 SHALL verify slots 0..2 = {1,13,0}, stepping rd_addr 0->1->2 -> half-periods 95555 then 47778, then audio_out=0 with playing=0, and phase reset at each change.
REQ-031 SHALL verify ld_note held 5 cycles with note_in 3,3,3,7,5 at wr_addr=4 -> mem[4]=5 on readback.
REQ-032 SHALL verify reset=0 asserted mid-tone (no clk edge) -> audio_out=0 and cur_note=0 immediately; after release, all slots read 0.
REQ-033 SHALL verify, with NOTE_GAP_EN and GAP_CYCLES=100, a next_note_en pulse during playback -> audio_out=0 for 100 cycles, then the tone starts low and first toggles HP cycles later.
REQ-034 SHALL verify ld_note=1 and ld_play=1 together -> the write occurs, audio_out stays 0, and cur_note=0.
